// File: rtl/envelope_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | envelope_pkg                                                       |
// | Shared types and sizing constants for the voice envelope block.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package envelope_pkg;

    localparam int c_default_voices  = 8;
    localparam int c_default_level_w = 16;
    localparam int c_vol_w           = 32;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage
`default_nettype wire

// File: rtl/envelope_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | envelope_step                                                      |
// | Combinational next-state / next-level function for one voice.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module envelope_step
    import envelope_pkg::*;
#(
    parameter int LEVEL_W = c_default_level_w
) (
    input  env_state_t         i_state,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic               i_gate,
    input  logic [LEVEL_W-1:0] i_attack_rate,
    input  logic [LEVEL_W-1:0] i_decay_rate,
    input  logic [LEVEL_W-1:0] i_release_rate,
    input  logic [LEVEL_W-1:0] i_sustain_level,
    output env_state_t         o_state,
    output logic [LEVEL_W-1:0] o_level
);

    localparam logic [LEVEL_W:0] c_full = {1'b0, {LEVEL_W{1'b1}}};

    env_state_t       w_gated;
    logic [LEVEL_W:0] w_att_sum;
    logic [LEVEL_W:0] w_dec_floor;
    logic [LEVEL_W:0] w_dec_diff;
    logic [LEVEL_W:0] w_rel_diff;

    // One extra bit exposes saturation on add and underflow on subtract
    assign w_att_sum   = {1'b0, i_level} + {1'b0, i_attack_rate};
    assign w_dec_floor = {1'b0, i_sustain_level} + {1'b0, i_decay_rate};
    assign w_dec_diff  = {1'b0, i_level} - {1'b0, i_decay_rate};
    assign w_rel_diff  = {1'b0, i_level} - {1'b0, i_release_rate};

    always_comb begin
        w_gated = i_state;
        if (i_gate && (i_state == ENV_IDLE || i_state == ENV_RELEASE))
            w_gated = ENV_ATTACK;
        else if (!i_gate && (i_state == ENV_ATTACK || i_state == ENV_DECAY ||
                             i_state == ENV_SUSTAIN))
            w_gated = ENV_RELEASE;
    end

    always_comb begin
        o_state = w_gated;
        o_level = i_level;
        case (w_gated)
            ENV_IDLE: begin
                o_level = '0;
            end
            ENV_ATTACK: begin
                if (i_attack_rate != '0 && w_att_sum >= c_full) begin
                    o_level = {LEVEL_W{1'b1}};
                    o_state = ENV_DECAY;
                end else begin
                    o_level = w_att_sum[LEVEL_W-1:0];
                end
            end
            ENV_DECAY: begin
                if ({1'b0, i_level} <= w_dec_floor) begin
                    o_level = i_sustain_level;
                    o_state = ENV_SUSTAIN;
                end else begin
                    o_level = w_dec_diff[LEVEL_W-1:0];
                end
            end
            ENV_SUSTAIN: begin
                o_level = i_sustain_level;
            end
            ENV_RELEASE: begin
                // A zero rate must hold, even at level 0, so it never reaches IDLE here
                if (i_release_rate != '0 && (w_rel_diff[LEVEL_W] || w_rel_diff == '0)) begin
                    o_level = '0;
                    o_state = ENV_IDLE;
                end else begin
                    o_level = w_rel_diff[LEVEL_W-1:0];
                end
            end
            default: begin
                o_level = '0;
                o_state = ENV_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/voice_envelope.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | voice_envelope                                                     |
// | ADSR envelopes for VOICES voices, swept one voice per clk per tick.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module voice_envelope
    import envelope_pkg::*;
#(
    parameter int VOICES  = c_default_voices,
    parameter int LEVEL_W = c_default_level_w
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             tick,
    input  logic [VOICES-1:0]                gate,
    input  logic [LEVEL_W-1:0]               attack_rate,
    input  logic [LEVEL_W-1:0]               decay_rate,
    input  logic [LEVEL_W-1:0]               release_rate,
    input  logic [LEVEL_W-1:0]               sustain_level,
    output logic [VOICES-1:0][c_vol_w-1:0]   voice_volumes,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun
);

    localparam int                 c_idx_w   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(VOICES - 1);
    localparam logic [0:0]         c_sw_idle = 1'b0;
    localparam logic [0:0]         c_sw_run  = 1'b1;

    logic [0:0]         r_sw_state;
    logic [0:0]         w_sw_next;
    logic               w_start;
    logic               w_update;
    logic               w_last;
    logic [c_idx_w-1:0] r_idx;
    logic [VOICES-1:0]  r_gate_snap;
    logic [LEVEL_W-1:0] r_attack;
    logic [LEVEL_W-1:0] r_decay;
    logic [LEVEL_W-1:0] r_release;
    logic [LEVEL_W-1:0] r_sustain;
    logic               r_overrun;
    env_state_t         r_state [VOICES];
    logic [LEVEL_W-1:0] r_level [VOICES];
    env_state_t         w_next_state;
    logic [LEVEL_W-1:0] w_next_level;

    assign w_last = (r_idx == c_last);

    always_ff @(posedge clk) begin
        if (!reset_n) r_sw_state <= c_sw_idle;
        else          r_sw_state <= w_sw_next;
    end

    always_comb begin
        w_sw_next = r_sw_state;
        case (r_sw_state)
            c_sw_idle: if (tick)   w_sw_next = c_sw_run;
            c_sw_run:  if (w_last) w_sw_next = c_sw_idle;
            default:               w_sw_next = c_sw_idle;
        endcase
    end

    always_comb begin
        busy     = (r_sw_state == c_sw_run);
        done     = (r_sw_state == c_sw_run) && w_last;
        w_update = (r_sw_state == c_sw_run);
        w_start  = (r_sw_state == c_sw_idle) && tick;
    end

    // Inputs are frozen at sweep start so every voice sees the same rates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_gate_snap <= '0;
            r_attack    <= '0;
            r_decay     <= '0;
            r_release   <= '0;
            r_sustain   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx       <= '0;
                r_gate_snap <= gate;
                r_attack    <= attack_rate;
                r_decay     <= decay_rate;
                r_release   <= release_rate;
                r_sustain   <= sustain_level;
            end else if (w_update) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            if (tick && busy) r_overrun <= 1'b1;
        end
    end

    envelope_step #(
        .LEVEL_W (LEVEL_W)
    ) u_step (
        .i_state         (r_state[r_idx]),
        .i_level         (r_level[r_idx]),
        .i_gate          (r_gate_snap[r_idx]),
        .i_attack_rate   (r_attack),
        .i_decay_rate    (r_decay),
        .i_release_rate  (r_release),
        .i_sustain_level (r_sustain),
        .o_state         (w_next_state),
        .o_level         (w_next_level)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < VOICES; k++) begin
                r_state[k] <= ENV_IDLE;
                r_level[k] <= '0;
            end
        end else if (w_update) begin
            r_state[r_idx] <= w_next_state;
            r_level[r_idx] <= w_next_level;
        end
    end

    assign overrun = r_overrun;

    generate
        for (genvar k = 0; k < VOICES; k++) begin : g_vol
            assign voice_volumes[k] = c_vol_w'(r_level[k]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_voice_envelope.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_voice_envelope                                                  |
// | Directed scoreboard bench for voice_envelope.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_voice_envelope;
    import envelope_pkg::*;

    typedef struct packed {
        env_state_t      st0;
        logic [7:0][15:0] lvl;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tick;
    logic [7:0]        gate;
    logic [15:0]       attack_rate;
    logic [15:0]       decay_rate;
    logic [15:0]       release_rate;
    logic [15:0]       sustain_level;
    logic [7:0][31:0]  voice_volumes;
    logic              busy;
    logic              done;
    logic              overrun;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q [$];

    voice_envelope dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .voice_volumes (voice_volumes),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] e0, input env_state_t s0, input logic [15:0] e3);
        exp_t e;
        e.lvl    = '0;
        e.lvl[0] = e0;
        e.lvl[3] = e3;
        e.st0    = s0;
        return e;
    endfunction

    // Once done is seen, the last voice lands on the following edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                @(posedge clk);
                #1;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    for (int v = 0; v < 8; v++)
                        check($sformatf("sweep_vol%0d", v), voice_volumes[v], {16'h0, e.lvl[v]});
                    check("sweep_state0", 32'(dut.r_state[0]), 32'(e.st0));
                end
            end
        end
    end

    task automatic set_in(input logic [7:0] g, input logic [15:0] att, dec, rel, sus);
        gate          = g;
        attack_rate   = att;
        decay_rate    = dec;
        release_rate  = rel;
        sustain_level = sus;
    endtask

    task automatic sweep(input logic [7:0] g, input logic [15:0] att, dec, rel, sus,
                         input logic [15:0] e0, input env_state_t s0, input logic [15:0] e3);
        int n;
        @(negedge clk);
        set_in(g, att, dec, rel, sus);
        sb_q.push_back(mk(e0, s0, e3));
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("sweep_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        set_in(8'h00, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int v = 0; v < 8; v++)
            check($sformatf("reset_vol%0d", v), voice_volumes[v], 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;

        // attack to full scale, then decay into sustain
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'h4000, ENV_ATTACK, 16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'h8000, ENV_ATTACK, 16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'hC000, ENV_ATTACK, 16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'hFFFF, ENV_DECAY,  16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'hDFFF, ENV_DECAY,  16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'hBFFF, ENV_DECAY,  16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'hA000, 16'hA000, ENV_SUSTAIN, 16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'h9000, 16'h9000, ENV_SUSTAIN, 16'h0);
        sweep(8'h01, 16'h4000, 16'h2000, 16'h1000, 16'h3000, 16'h3000, ENV_SUSTAIN, 16'h0);

        // release down to idle and stay there
        sweep(8'h00, 16'h4000, 16'h2000, 16'h1000, 16'h3000, 16'h2000, ENV_RELEASE, 16'h0);
        sweep(8'h00, 16'h4000, 16'h2000, 16'h1000, 16'h3000, 16'h1000, ENV_RELEASE, 16'h0);
        sweep(8'h00, 16'h4000, 16'h2000, 16'h1000, 16'h3000, 16'h0000, ENV_IDLE,    16'h0);
        sweep(8'h00, 16'h4000, 16'h2000, 16'h1000, 16'h3000, 16'h0000, ENV_IDLE,    16'h0);

        // zero release rate holds, retrigger continues from current level
        sweep(8'h09, 16'h5000, 16'h2000, 16'h0000, 16'h3000, 16'h5000, ENV_ATTACK,  16'h5000);
        sweep(8'h00, 16'h5000, 16'h2000, 16'h0000, 16'h3000, 16'h5000, ENV_RELEASE, 16'h5000);
        sweep(8'h01, 16'h1000, 16'h2000, 16'h0000, 16'h3000, 16'h6000, ENV_ATTACK,  16'h5000);

        // cycle-accurate sweep timing with a tick arriving mid-sweep
        @(negedge clk);
        set_in(8'h08, 16'h1000, 16'h2000, 16'h1000, 16'h3000);
        sb_q.push_back(mk(16'h5000, ENV_RELEASE, 16'h6000));
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("t_busy_c%0d", c), 32'(busy), (c <= 8) ? 32'd1 : 32'd0);
            check($sformatf("t_done_c%0d", c), 32'(done), (c == 8) ? 32'd1 : 32'd0);
            if (c == 4) check("t_vol3_before", voice_volumes[3], 32'h5000);
            if (c == 5) check("t_vol3_after", voice_volumes[3], 32'h6000);
            if (c == 5) check("t_overrun_pre", 32'(overrun), 32'd0);
            if (c == 6) check("t_overrun_set", 32'(overrun), 32'd1);
            if (c == 5) tick = 1'b1;
            if (c == 6) tick = 1'b0;
            @(posedge clk);
            #1;
        end

        // a tick on the done cycle is ignored
        @(negedge clk);
        set_in(8'h00, 16'h1000, 16'h2000, 16'h1000, 16'h3000);
        sb_q.push_back(mk(16'h4000, ENV_RELEASE, 16'h5000));
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 8)  check("d_done", 32'(done), 32'd1);
            if (c == 9)  check("d_busy_c9", 32'(busy), 32'd0);
            if (c == 10) check("d_busy_c10", 32'(busy), 32'd0);
            if (c == 8) tick = 1'b1;
            if (c == 9) tick = 1'b0;
            @(posedge clk);
            #1;
        end

        // reset in the middle of a sweep
        @(negedge clk);
        set_in(8'h00, 16'h1000, 16'h2000, 16'h1000, 16'h3000);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) reset_n = 1'b0;
            @(posedge clk);
            #1;
        end
        for (int v = 0; v < 8; v++)
            check($sformatf("mr_vol%0d", v), voice_volumes[v], 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_done", 32'(done), 32'h0);
        check("mr_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;

        sweep(8'h01, 16'h2000, 16'h2000, 16'h1000, 16'h3000, 16'h2000, ENV_ATTACK, 16'h0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
